// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-side handshake and HI/LO result bundle for the multiply/divide sequencer.
// The master drives the request side; the slave owns HI/LO and the stall status.
interface hilo_muldiv_ctrl_if;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        ReadHiLoIn;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic [31:0] RHi;
    logic [31:0] RLo;

    modport master (
        output Start, Op, A, B, Flush, ReadHiLoIn,
        input  Busy, Stall, Done, RHi, RLo
    );

    modport slave (
        input  Start, Op, A, B, Flush, ReadHiLoIn,
        output Busy, Stall, Done, RHi, RLo
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative 32-bit multiply/divide sequencer owning HI/LO; one shift-add or
// restoring shift-subtract step per cycle on magnitudes, sign fix-up at the end.
module hilo_muldiv_ctrl (
    input  logic               Clk,
    input  logic               Rst_n,
    hilo_muldiv_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        busy;

    // Request decode; Flush outranks Start in every state.
    logic        accept;
    logic        start_iter;
    logic        is_signed;
    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;

    assign accept     = (state_q == IDLE) && bus.Start && !bus.Flush;
    assign start_iter = accept && !bus.Op[2];
    assign is_signed  = !bus.Op[0];
    assign sign_a     = is_signed && bus.A[31];
    assign sign_b     = is_signed && bus.B[31];
    assign mag_a      = sign_a ? (~bus.A + 32'd1) : bus.A;
    assign mag_b      = sign_b ? (~bus.B + 32'd1) : bus.B;

    // One multiply step: add multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};

    // One restoring divide step; the shifted partial remainder needs 33 bits.
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_sub;
    logic [63:0] div_next;
    assign rem_sh   = acc_q[63:31];
    assign rem_ge   = rem_sh >= {1'b0, opnd_q};
    assign rem_sub  = rem_sh[31:0] - opnd_q;
    assign div_next = rem_ge ? {rem_sub, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};

    // Sign correction applied in FIX.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    assign prod_fix = neg_q     ? (~acc_q + 64'd1)         : acc_q;
    assign quo_fix  = neg_q     ? (~acc_q[31:0] + 32'd1)   : acc_q[31:0];
    assign rem_fix  = rem_neg_q ? (~acc_q[63:32] + 32'd1)  : acc_q[63:32];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_iter) state_d = RUN;
            RUN: begin
                if (bus.Flush)           state_d = IDLE;
                else if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        a_raw_d    = a_raw_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        if (start_iter) begin
            cnt_d      = 5'd0;
            is_div_d   = bus.Op[1];
            neg_d      = sign_a ^ sign_b;
            rem_neg_d  = sign_a;
            div_zero_d = (bus.B == 32'd0);
            a_raw_d    = bus.A;
            acc_d      = bus.Op[1] ? {32'd0, mag_a} : {32'd0, mag_b};
            opnd_d     = bus.Op[1] ? mag_b : mag_a;
        end else if (accept && bus.Op == OP_MTHI) begin
            hi_d = bus.A;
        end else if (accept && bus.Op == OP_MTLO) begin
            lo_d = bus.A;
        end

        if (state_q == RUN) begin
            cnt_d = cnt_q + 5'd1;
            acc_d = is_div_q ? div_next : mul_next;
        end

        if (state_q == FIX && !bus.Flush) begin
            done_d = 1'b1;
            if (!is_div_q) begin
                {hi_d, lo_d} = prod_fix;
            end else if (div_zero_q) begin
                hi_d = a_raw_q;
                lo_d = 32'hFFFF_FFFF;
            end else begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q      <= 5'd0;
            acc_q      <= 64'd0;
            opnd_q     <= 32'd0;
            a_raw_q    <= 32'd0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            a_raw_q    <= a_raw_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign bus.Busy  = busy;
    assign bus.Stall = busy && (bus.Start || bus.ReadHiLoIn);
    assign bus.Done  = done_q;
    assign bus.RHi   = hi_q;
    assign bus.RLo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: arithmetic corner cases, latency,
// stall behaviour, flush, write ordering and asynchronous reset.
module tb_hilo_muldiv_ctrl;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;

    logic Clk;
    logic Rst_n;
    int   n_vec;
    int   n_miss;

    hilo_muldiv_ctrl_if bus ();

    hilo_muldiv_ctrl u_dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present a request for one edge (E0), then drop Start.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic run_iter(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
        int cycles;
        issue(op, a, b);
        check({tag, " busy_after_e0"}, 64'(bus.Busy), 64'd1);
        cycles = 0;
        while (!bus.Done && cycles < 40) begin
            tick();
            cycles++;
        end
        check({tag, " done_latency"}, 64'(cycles), 64'd33);
        check({tag, " busy_in_done"}, 64'(bus.Busy), 64'd0);
        check({tag, " hi"}, 64'(bus.RHi), 64'(exp_hi));
        check({tag, " lo"}, 64'(bus.RLo), 64'(exp_lo));
        tick();
        check({tag, " done_one_cycle"}, 64'(bus.Done), 64'd0);
    endtask

    initial begin
        int stall_cnt;
        int done_seen;
        int busy_seen;
        int cycles;

        n_vec  = 0;
        n_miss = 0;
        Rst_n  = 1'b0;
        bus.Start      = 1'b1;
        bus.Op         = OP_MULT;
        bus.A          = 32'd0;
        bus.B          = 32'd0;
        bus.Flush      = 1'b0;
        bus.ReadHiLoIn = 1'b1;

        // Reset state
        #12;
        check("rst busy",  64'(bus.Busy),  64'd0);
        check("rst done",  64'(bus.Done),  64'd0);
        check("rst stall", 64'(bus.Stall), 64'd0);
        check("rst hi",    64'(bus.RHi),   64'd0);
        check("rst lo",    64'(bus.RLo),   64'd0);
        bus.Start      = 1'b0;
        bus.ReadHiLoIn = 1'b0;
        tick();
        Rst_n = 1'b1;
        tick();

        // Arithmetic
        run_iter("mult_neg",   OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_iter("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_iter("multu_2p32", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
        run_iter("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_iter("div_negb",   OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_iter("divu_basic", OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
        run_iter("divu_zero",  OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
        run_iter("div_zero",   OP_DIV,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_iter("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // mfhi/mflo in ID from E5 onward: stalled through FIX, free in the Done cycle
        issue(OP_MULT, 32'd3, 32'd5);
        repeat (4) tick();
        bus.ReadHiLoIn = 1'b1;
        #1;
        stall_cnt = 0;
        for (int k = 4; k <= 32; k++) begin
            if (bus.Stall) stall_cnt++;
            if (k < 32) tick();
        end
        check("stall cycles", 64'(stall_cnt), 64'd29);
        tick();
        check("stall done",    64'(bus.Done),  64'd1);
        check("stall released", 64'(bus.Stall), 64'd0);
        check("stall lo",      64'(bus.RLo),   64'd15);
        check("stall hi",      64'(bus.RHi),   64'd0);
        bus.ReadHiLoIn = 1'b0;
        tick();

        // mtlo held on Start behind a running mult
        issue(OP_MULT, 32'd2, 32'd3);
        bus.Start = 1'b1;
        bus.Op    = OP_MTLO;
        bus.A     = 32'h0000_1234;
        #1;
        check("hold stall", 64'(bus.Stall), 64'd1);
        cycles = 0;
        while (bus.Busy && cycles < 40) begin
            tick();
            cycles++;
        end
        check("hold busy_cycles", 64'(cycles), 64'd33);
        check("hold done_lo",     64'(bus.RLo),   64'd6);
        check("hold done_stall",  64'(bus.Stall), 64'd0);
        tick();
        bus.Start = 1'b0;
        check("hold final_lo", 64'(bus.RLo),  64'h1234);
        check("hold final_hi", 64'(bus.RHi),  64'd0);
        check("hold idle",     64'(bus.Busy), 64'd0);

        // mthi/mtlo direct writes, then flush mid-iteration
        issue(OP_MTHI, 32'h0000_AAAA, 32'd0);
        check("mthi hi",   64'(bus.RHi),  64'hAAAA);
        check("mthi busy", 64'(bus.Busy), 64'd0);
        issue(OP_MTLO, 32'h0000_5555, 32'd0);
        check("mtlo lo",   64'(bus.RLo),  64'h5555);
        check("mtlo done", 64'(bus.Done), 64'd0);
        issue(OP_MULT, 32'd7, 32'd9);
        repeat (10) tick();
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        check("flush busy", 64'(bus.Busy), 64'd0);
        check("flush hi",   64'(bus.RHi),  64'hAAAA);
        check("flush lo",   64'(bus.RLo),  64'h5555);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.Done) done_seen++;
            tick();
        end
        check("flush no_done", 64'(done_seen), 64'd0);

        // Flush beats Start in IDLE; reserved op has no effect
        bus.Flush = 1'b1;
        issue(OP_MTHI, 32'd1, 32'd0);
        bus.Flush = 1'b0;
        check("flush_prio hi", 64'(bus.RHi), 64'hAAAA);
        issue(OP_NOP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("nop busy", 64'(bus.Busy), 64'd0);
        check("nop hi",   64'(bus.RHi),  64'hAAAA);
        check("nop lo",   64'(bus.RLo),  64'h5555);

        // Asynchronous reset at counter=15
        issue(OP_MULT, 32'd7, 32'd9);
        repeat (15) tick();
        #1;
        Rst_n = 1'b0;
        #1;
        check("rstrun busy", 64'(bus.Busy), 64'd0);
        check("rstrun hi",   64'(bus.RHi),  64'd0);
        check("rstrun lo",   64'(bus.RLo),  64'd0);
        check("rstrun done", 64'(bus.Done), 64'd0);
        #1;
        Rst_n = 1'b1;
        done_seen = 0;
        busy_seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.Done) done_seen++;
            if (bus.Busy) busy_seen++;
        end
        check("rstrun no_done", 64'(done_seen), 64'd0);
        check("rstrun no_busy", 64'(busy_seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
